// File: rtl/uart_json_pkg.sv
// Shared constants for the motor-command JSON receiver: parser states,
// ASCII tokens, fixed literal fragments and move_cmd encodings.
package uart_json_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE   = 4'd0;
  localparam state_t S_HDR    = 4'd1;
  localparam state_t S_L_SIGN = 4'd2;
  localparam state_t S_L_INT  = 4'd3;
  localparam state_t S_L_DOT  = 4'd4;
  localparam state_t S_L_DIG  = 4'd5;
  localparam state_t S_MID    = 4'd6;
  localparam state_t S_R_SIGN = 4'd7;
  localparam state_t S_R_INT  = 4'd8;
  localparam state_t S_R_DOT  = 4'd9;
  localparam state_t S_R_DIG  = 4'd10;
  localparam state_t S_CLOSE  = 4'd11;
  localparam state_t S_EOL    = 4'd12;

  localparam logic [7:0] CH_LBRACE = 8'h7B;
  localparam logic [7:0] CH_RBRACE = 8'h7D;
  localparam logic [7:0] CH_MINUS  = 8'h2D;
  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_ZERO   = 8'h30;
  localparam logic [7:0] CH_NINE   = 8'h39;
  localparam logic [7:0] CH_LF     = 8'h0A;

  // Element [N-1] is the first byte on the wire.
  localparam logic [9:0][7:0] HDR = "\"T\":1,\"L\":";
  localparam logic [4:0][7:0] MID = ",\"R\":";

  localparam logic [3:0] MV_FWD       = 4'h0;
  localparam logic [3:0] MV_TURN_L    = 4'h1;
  localparam logic [3:0] MV_TURN_R    = 4'h2;
  localparam logic [3:0] MV_REV       = 4'h3;
  localparam logic [3:0] MV_SPIN_L    = 4'h4;
  localparam logic [3:0] MV_SPIN_R    = 4'h5;
  localparam logic [3:0] MV_REV_L     = 4'h6;
  localparam logic [3:0] MV_REV_R     = 4'h7;
  localparam logic [3:0] MV_UNMAPPED  = 4'hE;
  localparam logic [3:0] MV_STOP      = 4'hF;

  // Signs must already be normalised so that a zero digit is never negative.
  function automatic logic [7:0] decode_motion(input logic ln, input logic [3:0] ld,
                                               input logic rn, input logic [3:0] rd);
    logic [3:0] mv;
    logic [3:0] sp;
    mv = MV_UNMAPPED;
    sp = 4'd0;
    if (ld == 4'd0 && rd == 4'd0) begin
      mv = MV_STOP;
    end else if (ld == 4'd0) begin
      mv = rn ? MV_REV_L : MV_TURN_L;
      sp = rd;
    end else if (rd == 4'd0) begin
      mv = ln ? MV_REV_R : MV_TURN_R;
      sp = ld;
    end else if (ld == rd) begin
      sp = ld;
      case ({ln, rn})
        2'b00:   mv = MV_FWD;
        2'b11:   mv = MV_REV;
        2'b10:   mv = MV_SPIN_L;
        default: mv = MV_SPIN_R;
      endcase
    end
    return {mv, sp};
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART byte receiver: 2-flop synchroniser, mid-bit sampling, LSB first.
// Bad stop bit pulses frame_err instead of rx_valid.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_in,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic          sync1, sync2, line_q;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      line_q    <= 1'b1;
      state     <= RX_IDLE;
      cnt       <= '0;
      bit_idx   <= 3'd0;
      rx_byte   <= 8'd0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync1     <= uart_in;
      sync2     <= sync1;
      line_q    <= sync2;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          // Edge, not level: a line stuck low after a framing error must not re-trigger.
          if (line_q && !sync2) state <= RX_START;
        end
        RX_START: begin
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            state   <= sync2 ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == FULL_M1) begin
            cnt     <= '0;
            rx_byte <= {sync2, rx_byte[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (cnt == FULL_M1) begin
            cnt       <= '0;
            rx_valid  <= sync2;
            frame_err <= !sync2;
            state     <= RX_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_json_rx.sv
// Parses {"T":1,"L":<v>,"R":<v>}\n from a UART link and publishes the wheel
// values plus the equivalent move_cmd/speed_level; outputs change only on commit.
module uart_json_rx
  import uart_json_pkg::*;
#(
  parameter int CLKS_PER_BIT = 50_000_000 / 115_200,
  parameter int GAP_BITS     = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_in,
  output logic       l_neg,
  output logic [3:0] l_digit,
  output logic       r_neg,
  output logic [3:0] r_digit,
  output logic [3:0] move_cmd,
  output logic [3:0] speed_level,
  output logic       valid,
  output logic       frame_err,
  output logic       parse_err
);

  localparam int GAP_LIMIT = GAP_BITS * CLKS_PER_BIT;
  localparam int GW        = $clog2(GAP_LIMIT + 1);
  localparam logic [GW-1:0] GAP_M1 = GW'(GAP_LIMIT - 1);

  logic [7:0]    rx_byte;
  logic          rx_valid, rx_ferr;
  state_t        state, acc_state;
  logic [3:0]    idx;
  logic          byte_ok, is_digit;
  logic          l_neg_s, r_neg_s;
  logic [3:0]    l_dig_s, r_dig_s;
  logic [GW-1:0] gap_cnt;
  logic          ln_c, rn_c;
  logic [7:0]    motion;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .uart_in   (uart_in),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .frame_err (rx_ferr)
  );

  assign is_digit = (rx_byte >= CH_ZERO) && (rx_byte <= CH_NINE);
  // "-0.0" is published as positive zero.
  assign ln_c   = l_neg_s && (l_dig_s != 4'd0);
  assign rn_c   = r_neg_s && (r_dig_s != 4'd0);
  assign motion = decode_motion(ln_c, l_dig_s, rn_c, r_dig_s);

  always_comb begin
    byte_ok   = 1'b0;
    acc_state = state;
    case (state)
      S_IDLE: begin
        byte_ok   = 1'b1;
        acc_state = (rx_byte == CH_LBRACE) ? S_HDR : S_IDLE;
      end
      S_HDR: begin
        byte_ok   = (rx_byte == HDR[4'd9 - idx]);
        acc_state = (idx == 4'd9) ? S_L_SIGN : S_HDR;
      end
      S_L_SIGN: begin
        byte_ok   = (rx_byte == CH_MINUS) || (rx_byte == CH_ZERO);
        acc_state = (rx_byte == CH_MINUS) ? S_L_INT : S_L_DOT;
      end
      S_L_INT: begin byte_ok = (rx_byte == CH_ZERO); acc_state = S_L_DOT; end
      S_L_DOT: begin byte_ok = (rx_byte == CH_DOT);  acc_state = S_L_DIG; end
      S_L_DIG: begin byte_ok = is_digit;             acc_state = S_MID;   end
      S_MID: begin
        byte_ok   = (rx_byte == MID[3'd4 - idx[2:0]]);
        acc_state = (idx == 4'd4) ? S_R_SIGN : S_MID;
      end
      S_R_SIGN: begin
        byte_ok   = (rx_byte == CH_MINUS) || (rx_byte == CH_ZERO);
        acc_state = (rx_byte == CH_MINUS) ? S_R_INT : S_R_DOT;
      end
      S_R_INT: begin byte_ok = (rx_byte == CH_ZERO);   acc_state = S_R_DOT; end
      S_R_DOT: begin byte_ok = (rx_byte == CH_DOT);    acc_state = S_R_DIG; end
      S_R_DIG: begin byte_ok = is_digit;               acc_state = S_CLOSE; end
      S_CLOSE: begin byte_ok = (rx_byte == CH_RBRACE); acc_state = S_EOL;   end
      S_EOL:   begin byte_ok = (rx_byte == CH_LF);     acc_state = S_IDLE;  end
      default: begin byte_ok = 1'b0;                   acc_state = S_IDLE;  end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      idx         <= 4'd0;
      gap_cnt     <= '0;
      l_neg_s     <= 1'b0;
      r_neg_s     <= 1'b0;
      l_dig_s     <= 4'd0;
      r_dig_s     <= 4'd0;
      l_neg       <= 1'b0;
      l_digit     <= 4'd0;
      r_neg       <= 1'b0;
      r_digit     <= 4'd0;
      move_cmd    <= MV_STOP;
      speed_level <= 4'd0;
      valid       <= 1'b0;
      frame_err   <= 1'b0;
      parse_err   <= 1'b0;
    end else begin
      valid     <= 1'b0;
      parse_err <= 1'b0;
      frame_err <= rx_ferr;
      if (rx_ferr) begin
        state   <= S_IDLE;
        idx     <= 4'd0;
        gap_cnt <= '0;
      end else if (rx_valid) begin
        gap_cnt <= '0;
        if (byte_ok) begin
          state <= acc_state;
          idx   <= ((state == S_HDR || state == S_MID) && acc_state == state) ? idx + 4'd1 : 4'd0;
          case (state)
            S_L_SIGN: l_neg_s <= (rx_byte == CH_MINUS);
            S_L_DIG:  l_dig_s <= rx_byte[3:0];
            S_R_SIGN: r_neg_s <= (rx_byte == CH_MINUS);
            S_R_DIG:  r_dig_s <= rx_byte[3:0];
            S_EOL: begin
              l_neg       <= ln_c;
              l_digit     <= l_dig_s;
              r_neg       <= rn_c;
              r_digit     <= r_dig_s;
              move_cmd    <= motion[7:4];
              speed_level <= motion[3:0];
              valid       <= 1'b1;
            end
            default: ;
          endcase
        end else begin
          // A stray '{' is taken as the start of a fresh message.
          parse_err <= 1'b1;
          state     <= (rx_byte == CH_LBRACE) ? S_HDR : S_IDLE;
          idx       <= 4'd0;
        end
      end else if (state != S_IDLE) begin
        if (gap_cnt == GAP_M1) begin
          parse_err <= 1'b1;
          state     <= S_IDLE;
          idx       <= 4'd0;
          gap_cnt   <= '0;
        end else begin
          gap_cnt <= gap_cnt + 1'b1;
        end
      end
    end
  end

endmodule
